phase_bank: RTL and testbench
=============================

# phase_bank

Time-multiplexed phase-accumulator bank at the head of the pipelined synthesizer voice chain. It serves NBANKS voice slots round-robin, one slot per clock-enabled cycle. For each slot it turns the MIDI note number presented by the bank manager into a 24-bit wrapping phase. It forwards that phase, the note number and a valid flag to the quarter-sine stage.

## Interface
- NBANKS, 10: number of voice slots; slot counter wraps at NBANKS-1.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- clk_en  in  1  pipeline advance strobe; state holds when 0.
- i_midi  in  7  note number for the current slot; 0 = slot idle.
- o_midi  out  7  note number of the slot whose phase is on o_phase.
- o_valid  out  1  1 = o_phase/o_midi carry an active voice.
- o_phase  out  24  unsigned phase, full scale = one period (2^24).

## Operation
- Internal state: slot index idx (0..NBANKS-1); per-slot 24-bit accumulator acc[s]; per-slot last note last[s] (only with macro).
- On each clk_en=1 cycle with slot s = idx:
  - i_midi != 0: sum = (acc[s] + INC(i_midi)) mod 2^24. Then acc[s] <= sum, o_phase <= sum, o_midi <= i_midi, o_valid <= 1.
  - i_midi == 0: acc[s] <= 0, o_phase <= 0, o_midi <= 0, o_valid <= 0.
  - idx <= (idx == NBANKS-1) ? 0 : idx+1.
- INC(m) is a 128-entry constant table of 24-bit values, INC(m) = round(2^24 * 440 * 2^((m-69)/12) / 48000). The per-slot update rate is 48 kHz. Required entries include INC(57)=76896, INC(69)=153791, INC(81)=307582. INC(0) is unused.
- Accumulator overflow wraps silently; there is no saturation.
- Slots are independent; only slot idx is read or written in a cycle.

## Timing
- Latency: 1 clock-enabled cycle. Slot s input at enabled cycle k appears on the outputs after the edge ending cycle k.
- Idx advances only on enabled edges, so input/output slot alignment is preserved across clk_en gaps.
- clk_en=0: idx, acc[], last[] and all outputs hold their values exactly; i_midi is ignored.
- Reset (rst=0, any time, including mid-sequence): idx=0, all acc=0, all last=0, o_phase=0, o_midi=0, o_valid=0 immediately. The first enabled cycle after release processes slot 0.
- No handshake or backpressure; downstream samples outputs on its own clk_en.

## Configuration
- PHASE_BANK_RETRIGGER_EN defined:
  - last[s] is kept per slot.
  - When i_midi != 0 and i_midi != last[s], the slot restarts: sum = INC(i_midi), computed from acc=0.
  - last[s] <= i_midi every enabled visit, including 0.
- PHASE_BANK_RETRIGGER_EN undefined:
  - No last[] storage.
  - A changed note continues from the existing acc[s] without a phase discontinuity.

## Test plan
- Reset then idle: rst pulse low, all i_midi=0 for 20 enabled cycles -> o_valid=0, o_phase=0, o_midi=0 throughout.
- Single voice: slot 0 = 69, others 0 -> slot-0 outputs are 153791, then 307582, then 461373 on successive visits. o_midi=69 and o_valid=1 on slot-0 outputs only.
- Wrap-around: slot 0 = 69 for 110 visits -> 110th output is 139794 (16917010 - 2^24).
- Multi-voice/stall: slot 0 = 57, slot 3 = 81, with clk_en low for 5 cycles between enables:
  - outputs hold during the gap;
  - slot-3 outputs step by 307582;
  - slot-0 outputs step by 76896;
  - ordering and idx wrap 9->0 are unchanged by the gap.
- Note-off then re-on: slot 0 = 69 for 3 visits, 0 for 1 visit (output 0/valid 0), 69 again -> output 153791.
- Retrigger (macro defined): slot 0 = 69 for 2 visits, then 81 -> output 307582, with phase restarted. Macro undefined -> output 307582+307582=615164.
- Async reset mid-run: rst low between clock edges -> outputs read 0 before the next edge. Next enabled cycle after release serves slot 0.

Source files
------------

// File: rtl/phase_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | phase_bank: round-robin bank of NBANKS 24-bit wrapping phase             |
// | accumulators, one voice slot per clk_en cycle, MIDI note -> increment.   |
// | Option: PHASE_BANK_RETRIGGER_EN restarts a slot's phase on note change.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module phase_bank #(
  parameter int NBANKS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [6:0]  i_midi,
  output logic [6:0]  o_midi,
  output logic        o_valid,
  output logic [23:0] o_phase
);

  localparam int              C_IW   = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [C_IW-1:0] C_LAST = C_IW'(NBANKS - 1);

  // INC(m) = round(2^22 * 11/300 * 2^((m-69)/12)); semitone ratios held as
  // 2^(n/12) * 1e10, so everything stays exact integer math within 64 bits.
  function automatic logic [23:0] inc_calc(input int m);
    logic [63:0] r;
    logic [63:0] num;
    logic [63:0] q;
    int          oct;
    case ((m + 3) % 12)
      0:       r = 64'd10000000000;
      1:       r = 64'd10594630944;
      2:       r = 64'd11224620483;
      3:       r = 64'd11892071150;
      4:       r = 64'd12599210499;
      5:       r = 64'd13348398542;
      6:       r = 64'd14142135624;
      7:       r = 64'd14983070769;
      8:       r = 64'd15874010520;
      9:       r = 64'd16817928305;
      10:      r = 64'd17817974363;
      default: r = 64'd18877486254;
    endcase
    oct = (m + 3) / 12;
    num = (64'd11 * r) << (oct + 14);
    q   = (num + 64'd375000000000) / 64'd750000000000;
    return q[23:0];
  endfunction

  logic [23:0] w_inc_tab [128];

  for (genvar g = 0; g < 128; g++) begin : g_inc
    localparam logic [23:0] C_INC = inc_calc(g);
    assign w_inc_tab[g] = C_INC;
  end

  logic [C_IW-1:0] r_idx;
  logic [23:0]     r_acc [NBANKS];
  logic [23:0]     r_phase;
  logic [6:0]      r_midi;
  logic            r_valid;
  logic [23:0]     w_base;
  logic [23:0]     w_sum;
  logic            w_active;

  assign w_active = (i_midi != 7'd0);

`ifdef PHASE_BANK_RETRIGGER_EN
  logic [6:0] r_last [NBANKS];
  // A new note restarts the slot from zero phase.
  assign w_base = (i_midi != r_last[r_idx]) ? 24'd0 : r_acc[r_idx];
`else
  assign w_base = r_acc[r_idx];
`endif

  assign w_sum = w_base + w_inc_tab[i_midi];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_phase <= 24'd0;
      r_midi  <= 7'd0;
      r_valid <= 1'b0;
      for (int s = 0; s < NBANKS; s++) begin
        r_acc[s] <= 24'd0;
`ifdef PHASE_BANK_RETRIGGER_EN
        r_last[s] <= 7'd0;
`endif
      end
    end else if (clk_en) begin
      r_acc[r_idx] <= w_active ? w_sum : 24'd0;
      r_phase      <= w_active ? w_sum : 24'd0;
      r_midi       <= i_midi;
      r_valid      <= w_active;
`ifdef PHASE_BANK_RETRIGGER_EN
      r_last[r_idx] <= i_midi;
`endif
      r_idx <= (r_idx == C_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  assign o_phase = r_phase;
  assign o_midi  = r_midi;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_phase_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_phase_bank: randomized and directed stimulus for phase_bank, checked  |
// | against a per-slot arithmetic reference model.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_phase_bank;

  localparam int NBANKS = 10;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [6:0]  i_midi;
  logic [6:0]  o_midi;
  logic        o_valid;
  logic [23:0] o_phase;

  phase_bank #(.NBANKS(NBANKS)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .i_midi  (i_midi),
    .o_midi  (o_midi),
    .o_valid (o_valid),
    .o_phase (o_phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_idx;
  int m_acc  [NBANKS];
  int m_last [NBANKS];
  int m_phase;
  int m_midi;
  int m_valid;
  int slot_note [NBANKS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int inc_of(input int m);
    real f;
    f = 16777216.0 * 440.0 * (2.0 ** ((m - 69) / 12.0)) / 48000.0;
    return $rtoi(f + 0.5);
  endfunction

  task automatic model_reset();
    m_idx = 0;
    m_phase = 0;
    m_midi = 0;
    m_valid = 0;
    for (int s = 0; s < NBANKS; s++) begin
      m_acc[s] = 0;
      m_last[s] = 0;
    end
  endtask

  task automatic model_update(input int midi);
    int s;
    int base;
    s = m_idx;
    if (midi != 0) begin
      base = m_acc[s];
`ifdef PHASE_BANK_RETRIGGER_EN
      if (midi != m_last[s]) base = 0;
`endif
      m_acc[s] = (base + inc_of(midi)) % (1 << 24);
      m_phase = m_acc[s];
      m_midi = midi;
      m_valid = 1;
    end else begin
      m_acc[s] = 0;
      m_phase = 0;
      m_midi = 0;
      m_valid = 0;
    end
    m_last[s] = midi;
    m_idx = (m_idx + 1) % NBANKS;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".phase"}, 32'(o_phase), 32'(m_phase));
    check({tag, ".midi"},  32'(o_midi),  32'(m_midi));
    check({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
  endtask

  task automatic step(input logic en, input logic [6:0] midi, input string tag);
    clk_en = en;
    i_midi = midi;
    @(posedge clk);
    if (en) model_update(int'(midi));
    #1;
    check_outs(tag);
  endtask

  // one enabled visit using slot_note for the slot about to be served
  task automatic visit(input string tag);
    step(1'b1, 7'(slot_note[m_idx]), tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check_outs("reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    for (int s = 0; s < NBANKS; s++) slot_note[s] = 0;
  endtask

  initial begin
    int exp_single [3];
    int prev0;
    int prev3;
    int seen0;
    int seen3;
    int slot;
    rst = 1'b1;
    clk_en = 1'b0;
    i_midi = 7'd0;
    model_reset();
    #3;

    // reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) visit("idle");

    // single voice on slot 0
    do_reset();
    slot_note[0] = 69;
    exp_single[0] = 153791;
    exp_single[1] = 307582;
    exp_single[2] = 461373;
    for (int v = 0; v < 3; v++) begin
      for (int s = 0; s < NBANKS; s++) begin
        visit("single");
        if (s == 0) check("single.abs", 32'(o_phase), 32'(exp_single[v]));
      end
    end

    // wrap-around: 110th visit of slot 0 at note 69
    for (int v = 3; v < 110; v++) begin
      for (int s = 0; s < NBANKS; s++) begin
        visit("wrap");
        if (s == 0 && v == 109) check("wrap.abs", 32'(o_phase), 32'd139794);
      end
    end

    // multi-voice with 5-cycle clk_en gaps
    do_reset();
    slot_note[0] = 57;
    slot_note[3] = 81;
    seen0 = 0;
    seen3 = 0;
    prev0 = 0;
    prev3 = 0;
    for (int i = 0; i < 3 * NBANKS + 4; i++) begin
      slot = m_idx;
      visit("stall");
      if (slot == 0) begin
        if (seen0 != 0) check("stall.step0", 32'((o_phase - prev0) % (1 << 24)), 32'd76896);
        prev0 = int'(o_phase);
        seen0 = 1;
      end
      if (slot == 3) begin
        if (seen3 != 0) check("stall.step3", 32'((o_phase - prev3) % (1 << 24)), 32'd307582);
        prev3 = int'(o_phase);
        seen3 = 1;
      end
      for (int g = 0; g < 5; g++) step(1'b0, 7'($urandom_range(0, 127)), "gap");
    end

    // note-off then re-on
    do_reset();
    slot_note[0] = 69;
    for (int v = 0; v < 3; v++)
      for (int s = 0; s < NBANKS; s++) visit("offon");
    slot_note[0] = 0;
    for (int s = 0; s < NBANKS; s++) begin
      visit("offon");
      if (s == 0) check("off.valid", 32'(o_valid), 32'd0);
    end
    slot_note[0] = 69;
    visit("offon");
    check("reon.abs", 32'(o_phase), 32'd153791);

    // retrigger on note change
    do_reset();
    slot_note[0] = 69;
    for (int v = 0; v < 2; v++)
      for (int s = 0; s < NBANKS; s++) visit("retrig");
    slot_note[0] = 81;
    visit("retrig");
`ifdef PHASE_BANK_RETRIGGER_EN
    check("retrig.abs", 32'(o_phase), 32'd307582);
`else
    check("retrig.abs", 32'(o_phase), 32'd615164);
`endif

    // async reset between edges
    for (int s = 0; s < NBANKS; s++) slot_note[s] = 20 + s;
    for (int i = 0; i < 13; i++) visit("pre_async");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    #2;
    rst = 1'b1;
    slot_note[0] = 69;
    visit("post_async");
    check("post_async.slot0", 32'(o_phase), 32'd153791);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 9) < 4) slot_note[m_idx] = 0;
        else slot_note[m_idx] = int'($urandom_range(1, 127));
      end
      if ($urandom_range(0, 3) != 0) visit("rand");
      else step(1'b0, 7'($urandom_range(0, 127)), "rand_hold");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
